// File: rtl/pcie_rst_pkg.sv
// Shared types and default timing constants for the PCIe reset sequencer.
// Optional watchdog build switch: PCIE_RST_TIMEOUT_EN.
package pcie_rst_pkg;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_PHY_WAIT = 3'd2,
        ST_STAGGER  = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } rst_seq_state_e;

    localparam int ASSERT_CYCLES_DEF  = 16;
    localparam int STAGGER_CYCLES_DEF = 8;
    localparam int LOCK_TIMEOUT_DEF   = 1024;

endpackage

// File: rtl/rst_seq_counter.sv
// Loadable, clearable up-counter that saturates at i_term.
// o_tc is high while the count sits at the terminal value.
module rst_seq_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_load_val > i_term) ? i_term : i_load_val;
        end else if (i_en && (r_cnt < i_term)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt >= i_term);

endmodule

// File: rtl/pcie_rst_sequencer.sv
// PCIe PHY bring-up reset sequencer: hold, PLL lock, PHY ready, staggered release.
// Define PCIE_RST_TIMEOUT_EN to add the PLL/PHY wait watchdog and ERROR state.
module pcie_rst_sequencer
    import pcie_rst_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int ASSERT_CYCLES  = ASSERT_CYCLES_DEF,
    parameter int STAGGER_CYCLES = STAGGER_CYCLES_DEF,
    parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pll_lock_i,
    input  logic                   phy_ready_i,
    input  logic                   soft_rst_req_i,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] dom_rst_o,
    output logic                   seq_done_o,
    output logic                   seq_err_o,
    output logic [2:0]             state_o
);

    localparam int HOLD_MAX = (ASSERT_CYCLES > STAGGER_CYCLES) ?
                              ASSERT_CYCLES : STAGGER_CYCLES;
    localparam int CW = $clog2(HOLD_MAX) + 1;
    localparam int IW = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CW-1:0] HOLD_TERM = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] STAG_TERM = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DOMAINS - 1);

    rst_seq_state_e         r_state;
    logic                   r_pll_rst;
    logic [NUM_DOMAINS-1:0] r_dom_rst;
    logic                   r_seq_done;
    logic                   r_seq_err;
    logic                   r_lock_seen;
    logic [IW-1:0]          r_idx;

    logic          w_lock_loss;
    logic          w_restart;
    logic          w_pll_go;
    logic          w_phy_go;
    logic          w_cnt_en;
    logic          w_cnt_clr;
    logic          w_cnt_tc;
    logic [CW-1:0] w_cnt_term;
    logic [CW-1:0] w_hold_cnt_unused;
    logic          w_wd_tc;

    assign w_lock_loss = !pll_lock_i &&
                         ((r_state == ST_PHY_WAIT) ||
                          (r_state == ST_STAGGER)  ||
                          (r_state == ST_DONE));
    assign w_restart   = soft_rst_req_i || w_lock_loss;
    assign w_pll_go    = (r_state == ST_PLL_WAIT) && pll_lock_i && r_lock_seen;
    assign w_phy_go    = (r_state == ST_PHY_WAIT) && phy_ready_i;

    // One counter serves both the initial hold and each stagger gap
    assign w_cnt_en   = (r_state == ST_RESET) || (r_state == ST_STAGGER);
    assign w_cnt_term = (r_state == ST_RESET) ? HOLD_TERM : STAG_TERM;
    assign w_cnt_clr  = w_restart || !w_cnt_en || w_cnt_tc;

    rst_seq_counter #(.W(CW)) u_hold_cnt (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_term     (w_cnt_term),
        .o_cnt      (w_hold_cnt_unused),
        .o_tc       (w_cnt_tc)
    );

`ifdef PCIE_RST_TIMEOUT_EN
    localparam int WW = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [WW-1:0] WD_TERM = WW'(LOCK_TIMEOUT - 1);

    logic          w_wd_en;
    logic          w_wd_clr;
    logic [WW-1:0] w_wd_cnt_unused;

    assign w_wd_en  = (r_state == ST_PLL_WAIT) || (r_state == ST_PHY_WAIT);
    assign w_wd_clr = w_restart || !w_wd_en || w_pll_go ||
                      w_phy_go || w_wd_tc;

    rst_seq_counter #(.W(WW)) u_wd_cnt (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_clr      (w_wd_clr),
        .i_en       (w_wd_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_term     (WD_TERM),
        .o_cnt      (w_wd_cnt_unused),
        .o_tc       (w_wd_tc)
    );
`else
    logic w_lock_timeout_unused;

    assign w_wd_tc               = 1'b0;
    assign w_lock_timeout_unused = ^LOCK_TIMEOUT;
`endif

    // rst_i, soft request and lock loss all land in the same clean RESET
    always_ff @(posedge clk_i) begin
        if (rst_i || w_restart) begin
            r_state     <= ST_RESET;
            r_pll_rst   <= 1'b1;
            r_dom_rst   <= '1;
            r_seq_done  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_lock_seen <= 1'b0;
            r_idx       <= '0;
        end else begin
            unique case (r_state)
                ST_RESET: begin
                    if (w_cnt_tc) begin
                        r_state   <= ST_PLL_WAIT;
                        r_pll_rst <= 1'b0;
                    end
                end
                ST_PLL_WAIT: begin
                    if (w_wd_tc) begin
                        r_state   <= ST_ERROR;
                        r_seq_err <= 1'b1;
                        r_pll_rst <= 1'b1;
                        r_dom_rst <= '1;
                    end else if (w_pll_go) begin
                        r_state      <= ST_PHY_WAIT;
                        r_dom_rst[0] <= 1'b0;
                    end else begin
                        r_lock_seen <= pll_lock_i;
                    end
                end
                ST_PHY_WAIT: begin
                    if (w_wd_tc) begin
                        r_state   <= ST_ERROR;
                        r_seq_err <= 1'b1;
                        r_pll_rst <= 1'b1;
                        r_dom_rst <= '1;
                    end else if (w_phy_go) begin
                        if (NUM_DOMAINS == 1) begin
                            r_state    <= ST_DONE;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_state <= ST_STAGGER;
                            r_idx   <= IW'(1);
                        end
                    end
                end
                ST_STAGGER: begin
                    if (w_cnt_tc) begin
                        for (int i = 1; i < NUM_DOMAINS; i++) begin
                            if (r_idx == IW'(i)) r_dom_rst[i] <= 1'b0;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state    <= ST_DONE;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                end
                default: begin
                    r_state <= ST_RESET;
                end
            endcase
        end
    end

    assign pll_rst_o  = r_pll_rst;
    assign dom_rst_o  = r_dom_rst;
    assign seq_done_o = r_seq_done;
    assign seq_err_o  = r_seq_err;
    assign state_o    = r_state;

endmodule

// File: tb/tb_pcie_rst_sequencer.sv
// Directed self-checking bench for pcie_rst_sequencer.
// Watchdog checks run when PCIE_RST_TIMEOUT_EN is defined.
module tb_pcie_rst_sequencer;

    logic       clk_i;
    logic       rst_i;
    logic       pll_lock_i;
    logic       phy_ready_i;
    logic       soft_rst_req_i;
    logic       pll_rst_o;
    logic [2:0] dom_rst_o;
    logic       seq_done_o;
    logic       seq_err_o;
    logic [2:0] state_o;

    int n_total = 0;
    int n_bad   = 0;

    pcie_rst_sequencer #(
        .NUM_DOMAINS    (3),
        .ASSERT_CYCLES  (16),
        .STAGGER_CYCLES (8),
        .LOCK_TIMEOUT   (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pll_lock_i     (pll_lock_i),
        .phy_ready_i    (phy_ready_i),
        .soft_rst_req_i (soft_rst_req_i),
        .pll_rst_o      (pll_rst_o),
        .dom_rst_o      (dom_rst_o),
        .seq_done_o     (seq_done_o),
        .seq_err_o      (seq_err_o),
        .state_o        (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_pll"}, pll_rst_o, 1);
        chk({tag, "_dom"}, dom_rst_o, 3'b111);
        chk({tag, "_done"}, seq_done_o, 0);
        chk({tag, "_err"}, seq_err_o, 0);
    endtask

    // 16 edges from a fresh hold count to PLL_WAIT
    task automatic hold_to_pll(input string tag);
        tick(15);
        chk({tag, "_hold_st"}, state_o, 0);
        chk({tag, "_hold_pll"}, pll_rst_o, 1);
        tick(1);
        chk({tag, "_pll_st"}, state_o, 1);
        chk({tag, "_pll_rel"}, pll_rst_o, 0);
        chk({tag, "_pll_dom"}, dom_rst_o, 3'b111);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1);
    end

    initial begin
        rst_i          = 1'b1;
        pll_lock_i     = 1'b1;
        phy_ready_i    = 1'b0;
        soft_rst_req_i = 1'b0;
        tick(3);
        chk_rst("por");
        rst_i = 1'b0;

        // nominal bring-up
        hold_to_pll("t1");
        tick(1);
        chk("t1_pll2_st", state_o, 1);
        chk("t1_pll2_dom", dom_rst_o, 3'b111);
        tick(1);
        chk("t1_phy_st", state_o, 2);
        chk("t1_phy_dom", dom_rst_o, 3'b110);
        tick(4);
        chk("t1_phywait", state_o, 2);
        phy_ready_i = 1'b1;
        tick(1);
        chk("t1_stag_st", state_o, 3);
        phy_ready_i = 1'b0;
        tick(7);
        chk("t1_d1_hold", dom_rst_o, 3'b110);
        tick(1);
        chk("t1_d1_rel", dom_rst_o, 3'b100);
        chk("t1_d1_st", state_o, 3);
        tick(7);
        chk("t1_d2_hold", dom_rst_o, 3'b100);
        chk("t1_d2_nodone", seq_done_o, 0);
        tick(1);
        chk("t1_d2_rel", dom_rst_o, 3'b000);
        chk("t1_done", seq_done_o, 1);
        chk("t1_done_st", state_o, 4);
        chk("t1_pll_off", pll_rst_o, 0);
        tick(5);
        chk("t1_stay", state_o, 4);

        // lock loss in DONE, then a single-cycle lock pulse in PLL_WAIT
        pll_lock_i = 1'b0;
        tick(1);
        chk_rst("t3");
        hold_to_pll("t3");
        pll_lock_i = 1'b1;
        tick(1);
        pll_lock_i = 1'b0;
        tick(5);
        chk("t2_stuck_st", state_o, 1);
        chk("t2_stuck_dom", dom_rst_o, 3'b111);
        pll_lock_i = 1'b1;
        tick(2);
        chk("t2_lock_st", state_o, 2);
        chk("t2_lock_dom", dom_rst_o, 3'b110);

        // soft request and lock loss in the same STAGGER cycle
        phy_ready_i = 1'b1;
        tick(1);
        chk("t4_stag", state_o, 3);
        tick(3);
        soft_rst_req_i = 1'b1;
        pll_lock_i     = 1'b0;
        tick(1);
        soft_rst_req_i = 1'b0;
        pll_lock_i     = 1'b1;
        chk_rst("t4");
        hold_to_pll("t4");

        // rst_i mid-STAGGER with idx=1
        tick(2);
        chk("t5_phy", state_o, 2);
        tick(1);
        chk("t5_stag", state_o, 3);
        phy_ready_i = 1'b0;
        tick(3);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        chk_rst("t5");

        // soft request inside RESET restarts the hold count
        tick(10);
        soft_rst_req_i = 1'b1;
        tick(1);
        soft_rst_req_i = 1'b0;
        chk("t6_soft_st", state_o, 0);
        hold_to_pll("t6");
        tick(2);
        phy_ready_i = 1'b1;
        tick(1);
        chk("t6_stag", state_o, 3);
        phy_ready_i = 1'b0;
        tick(8);
        chk("t6_idx1_first", dom_rst_o, 3'b100);
        tick(8);
        chk("t6_idx2", dom_rst_o, 3'b000);
        chk("t6_done", seq_done_o, 1);

        // PLL never locks
        pll_lock_i     = 1'b0;
        soft_rst_req_i = 1'b1;
        tick(1);
        soft_rst_req_i = 1'b0;
        chk_rst("t7");
        hold_to_pll("t7");
`ifdef PCIE_RST_TIMEOUT_EN
        tick(31);
        chk("t7_wd_pre_st", state_o, 1);
        chk("t7_wd_pre_err", seq_err_o, 0);
        tick(1);
        chk("t7_err_st", state_o, 5);
        chk("t7_err", seq_err_o, 1);
        chk("t7_err_pll", pll_rst_o, 1);
        chk("t7_err_dom", dom_rst_o, 3'b111);
        chk("t7_err_done", seq_done_o, 0);
        tick(3);
        chk("t7_err_hold", state_o, 5);
        soft_rst_req_i = 1'b1;
        tick(1);
        soft_rst_req_i = 1'b0;
        chk_rst("t7_exit");
`else
        tick(40);
        chk("t7_nowd_st", state_o, 1);
        chk("t7_nowd_err", seq_err_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
